mem_line_arbiter: RTL

//  Upstream front-end of the line-wide RAM wrapper. Arbitrates one instruction-cache and one

---
 rtl/mem_line_arbiter_pkg.sv | 20 ++
 rtl/mem_line_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_line_arbiter_pkg.sv
// Shared types and default line geometry for the cache-to-RAM line arbiter.
package mem_line_arbiter_pkg;

   localparam int DEF_WORD_WIDTH  = 32;
   localparam int BLK_SIZE        = 128;
   localparam int WORDS_PER_LINE  = BLK_SIZE / DEF_WORD_WIDTH;
   localparam int LINE_ADDR_BITS  = $clog2(WORDS_PER_LINE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_I = 1'b0,
      PORT_D = 1'b1
   } mem_port_e;

endpackage

// File: rtl/mem_line_arbiter.sv
// Arbitrates the I-cache and D-cache line ports onto one line-wide RAM port,
// one transaction at a time, with a registered single-cycle RAM read.
// Build option: MEM_ARB_RR_EN selects round-robin arbitration (default is
// fixed D-over-I priority).
//
// state | meaning
// IDLE  | waiting for a request; ready is offered to the granted port
// ISSUE | RAM command presented for one cycle
// RESP  | RAM read data available; response pulse is being registered
module mem_line_arbiter
   import mem_line_arbiter_pkg::*;
#(
   parameter int WORD_WIDTH       = DEF_WORD_WIDTH,
   parameter int RAM_DEPTH        = 32768,
   parameter int CACHE_LINE_WIDTH = BLK_SIZE,
   parameter int ADDR_WIDTH       = 32
)(
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          prog_busy_i,
   input  logic                          ireq_valid_i,
   output logic                          ireq_ready_o,
   input  logic [ADDR_WIDTH-1:0]         ireq_addr_i,
   output logic                          irsp_valid_o,
   output logic                          irsp_err_o,
   output logic [CACHE_LINE_WIDTH-1:0]   irsp_data_o,
   input  logic                          dreq_valid_i,
   output logic                          dreq_ready_o,
   input  logic [ADDR_WIDTH-1:0]         dreq_addr_i,
   input  logic [CACHE_LINE_WIDTH-1:0]   dreq_wdata_i,
   input  logic [CACHE_LINE_WIDTH/8-1:0] dreq_wstrb_i,
   output logic                          drsp_valid_o,
   output logic                          drsp_err_o,
   output logic [CACHE_LINE_WIDTH-1:0]   drsp_data_o,
   output logic [$clog2(RAM_DEPTH)-1:0]  ram_addr_o,
   output logic [CACHE_LINE_WIDTH-1:0]   ram_wdata_o,
   output logic [CACHE_LINE_WIDTH/8-1:0] ram_wstrb_o,
   output logic                          ram_rd_en_o,
   input  logic [CACHE_LINE_WIDTH-1:0]   ram_rdata_i
);

   localparam int RAM_AW    = $clog2(RAM_DEPTH);
   localparam int LINE_BITS = $clog2(CACHE_LINE_WIDTH / WORD_WIDTH);
   localparam int STRB_W    = CACHE_LINE_WIDTH / 8;
   localparam logic [ADDR_WIDTH:0] RANGE_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH) << 2;

   arb_state_e                  r_state;
   arb_state_e                  w_state_nxt;
   mem_port_e                   r_port;
   logic                        r_wr;
   logic                        r_err;
   logic [RAM_AW-1:0]           r_ram_addr;
   logic [CACHE_LINE_WIDTH-1:0] r_ram_wdata;
   logic [STRB_W-1:0]           r_ram_wstrb;
   logic                        r_ram_rd_en;
   logic                        r_irsp_valid;
   logic                        r_irsp_err;
   logic [CACHE_LINE_WIDTH-1:0] r_irsp_data;
   logic                        r_drsp_valid;
   logic                        r_drsp_err;
   logic [CACHE_LINE_WIDTH-1:0] r_drsp_data;

   logic                        w_prio_d;
   logic                        w_gnt_d;
   logic                        w_gnt_i;
   logic                        w_open;
   logic                        w_accept;
   logic [ADDR_WIDTH-1:0]       w_req_addr;
   logic                        w_req_err;
   logic                        w_req_wr;
   logic [RAM_AW-1:0]           w_req_idx;

`ifdef MEM_ARB_RR_EN
   mem_port_e                   r_last_grant;

   // Remember the last winner so a tie goes to the other port next time.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         r_last_grant <= PORT_I;
      else if (w_accept) r_last_grant <= w_gnt_d ? PORT_D : PORT_I;
   end

   assign w_prio_d = (r_last_grant == PORT_I);
`else
   assign w_prio_d = 1'b1;
`endif

   assign w_gnt_d      = dreq_valid_i & (~ireq_valid_i | w_prio_d);
   assign w_gnt_i      = ireq_valid_i & ~w_gnt_d;
   assign w_open       = (r_state == IDLE) & ~prog_busy_i;
   assign ireq_ready_o = w_open & w_gnt_i;
   assign dreq_ready_o = w_open & w_gnt_d;
   assign w_accept     = ireq_ready_o | dreq_ready_o;

   assign w_req_addr = w_gnt_d ? dreq_addr_i : ireq_addr_i;
   assign w_req_err  = ({1'b0, w_req_addr} >= RANGE_LIM);
   assign w_req_wr   = w_gnt_d & (|dreq_wstrb_i);
   assign w_req_idx  = {w_req_addr[RAM_AW+1:2+LINE_BITS], {LINE_BITS{1'b0}}};

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state: one fixed three-cycle walk per accepted request.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_nxt = ISSUE;
         ISSUE:   w_state_nxt = RESP;
         RESP:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Latch the transaction attributes needed again at response time.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_port <= PORT_I;
         r_wr   <= 1'b0;
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_port <= w_gnt_d ? PORT_D : PORT_I;
         r_wr   <= w_req_wr;
         r_err  <= w_req_err;
      end
   end

   // RAM command is loaded on accept and held only for the ISSUE cycle;
   // out-of-range requests never touch the RAM.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ram_wstrb <= '0;
         r_ram_rd_en <= 1'b0;
      end else begin
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ram_wstrb <= '0;
         r_ram_rd_en <= 1'b0;
         if (w_accept && !w_req_err) begin
            r_ram_addr <= w_req_idx;
            if (w_req_wr) begin
               r_ram_wdata <= dreq_wdata_i;
               r_ram_wstrb <= dreq_wstrb_i;
            end else begin
               r_ram_rd_en <= 1'b1;
            end
         end
      end
   end

   // Single response pulse on the latched port, built from RAM data during RESP.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_irsp_valid <= 1'b0;
         r_irsp_err   <= 1'b0;
         r_irsp_data  <= '0;
         r_drsp_valid <= 1'b0;
         r_drsp_err   <= 1'b0;
         r_drsp_data  <= '0;
      end else begin
         r_irsp_valid <= 1'b0;
         r_irsp_err   <= 1'b0;
         r_irsp_data  <= '0;
         r_drsp_valid <= 1'b0;
         r_drsp_err   <= 1'b0;
         r_drsp_data  <= '0;
         if (r_state == RESP) begin
            if (r_port == PORT_D) begin
               r_drsp_valid <= 1'b1;
               r_drsp_err   <= r_err;
               r_drsp_data  <= (r_wr || r_err) ? '0 : ram_rdata_i;
            end else begin
               r_irsp_valid <= 1'b1;
               r_irsp_err   <= r_err;
               r_irsp_data  <= r_err ? '0 : ram_rdata_i;
            end
         end
      end
   end

   assign ram_addr_o   = r_ram_addr;
   assign ram_wdata_o  = r_ram_wdata;
   assign ram_wstrb_o  = r_ram_wstrb;
   assign ram_rd_en_o  = r_ram_rd_en;
   assign irsp_valid_o = r_irsp_valid;
   assign irsp_err_o   = r_irsp_err;
   assign irsp_data_o  = r_irsp_data;
   assign drsp_valid_o = r_drsp_valid;
   assign drsp_err_o   = r_drsp_err;
   assign drsp_data_o  = r_drsp_data;

endmodule
